sensor_serial_rx: RTL and testbench
===================================

Name: sensor_serial_rx

Overview:
- Parametrised successor to the team's fixed 8-bit serial input receiver.
- Runs entirely in the system CLK domain: synchronises the external serial clock, data and select lines, detects serial-clock rising edges, and assembles WIDTH-bit words with selectable bit order.
- Adds a framing select, a one-cycle word-valid strobe, inter-bit timeout recovery and frame-error reporting.
- Sits between the sensor pins and the navigation datapath registers.

Parameters:
- WIDTH, 8, bits per word (2..32).
- LSB_FIRST, 1, 1 = first received bit goes to DATA[0]; 0 = first received bit goes to DATA[WIDTH-1].
- SYNC_STAGES, 2, flip-flops in each input synchroniser (>=2).
- TIMEOUT_CYCLES, 1024, CLK cycles without a serial-clock edge before a partial word is discarded (>=4).

Ports:
- CLK  input  1  system clock; all state is on the posedge.
- RESET  input  1  synchronous, active-high reset.
- RCLK  input  1  asynchronous serial clock from sensor; data is sampled on its rising edge.
- RDATA  input  1  asynchronous serial data.
- RSEL  input  1  asynchronous frame select, active-high; a word is valid only while RSEL is held high.
- DATA  output  WIDTH  last complete word; held until the next word completes.
- DATA_VALID  output  1  one-CLK pulse when DATA updates.
- FRAME_ERR  output  1  one-CLK pulse when a partial word is discarded.
- BUSY  output  1  high while 1..WIDTH-1 bits of the current word are captured.

Behaviour:
- Reset (RESET high at a CLK edge): DATA=0, DATA_VALID=0, FRAME_ERR=0, BUSY=0, bit counter=0, timeout counter=0, state=IDLE, synchroniser flops=0. Reset mid-word discards the partial word and raises no FRAME_ERR.
- Synchronisation: RCLK, RDATA and RSEL each pass through SYNC_STAGES flops. A rise event is registered rclk_s && !rclk_prev. RDATA is sampled from its synchronised copy in the same cycle as the rise event.
- Sample event: rise event AND synchronised RSEL == 1. A rise event while RSEL is low is ignored.
- States:
  - IDLE: counter=0. A sample event stores the bit and moves to SHIFT with counter=1. If WIDTH bits are now complete, the word completes instead.
  - SHIFT: each sample event stores the bit and increments the counter.
    - Word complete (counter reaches WIDTH): DATA <= assembled word, DATA_VALID=1 in the next cycle, return to IDLE.
    - Synchronised RSEL low, or timeout counter reaches TIMEOUT_CYCLES-1 with no edge: discard the partial word, FRAME_ERR=1 for one cycle, return to IDLE. DATA is unchanged.
- Bit order:
  - LSB_FIRST=1: bit n of the word lands at DATA[n].
  - LSB_FIRST=0: shift left; the first received bit ends at DATA[WIDTH-1].
- Latency: DATA/DATA_VALID update 1 CLK after the final sample event, i.e. SYNC_STAGES+2 CLK cycles after the RCLK pin edge.
- Timeout counter: width $clog2(TIMEOUT_CYCLES). Cleared on every sample event and in IDLE. Saturates; never wraps.
- Simultaneous events:
  - RSEL low in the same synchronised cycle as a rise event: the edge is not sampled. An incomplete word gives FRAME_ERR.
  - Final bit and timeout in the same cycle: the sample event wins, and DATA_VALID fires with no FRAME_ERR.
  - DATA_VALID and FRAME_ERR are never high in the same cycle.
- Back-to-back words with RSEL held high are supported. The counter wraps to 0 after each complete word, with no gap cycle required.
- Minimum RCLK high and low time: SYNC_STAGES+1 CLK periods. Faster RCLK is out of spec and unverified.

Decomposition:
- Shared package sensor_serial_pkg: state enum (IDLE, SHIFT), helper function for the timeout counter width.
- Sub-module serial_sync_edge: parametrised SYNC_STAGES synchroniser for one bit, with a rise-detect output. Instantiated for RCLK (edge used) and for RDATA and RSEL (level only).

Test Plan:
- Reset then idle: RESET 3 cycles, RCLK toggling with RSEL=0 -> DATA=0x00, no DATA_VALID, no FRAME_ERR, BUSY=0.
- LSB-first byte: WIDTH=8, LSB_FIRST=1, RSEL=1, bits 1,0,1,0,0,1,0,1 -> DATA=0xA5, one DATA_VALID pulse exactly SYNC_STAGES+2 CLK after the 8th RCLK rise.
- MSB-first 12-bit: WIDTH=12, LSB_FIRST=0, send 0xC3A MSB first -> DATA=0xC3A, DATA_VALID once. Immediately send 0x001 back-to-back -> second pulse with DATA=0x001.
- RSEL abort: 5 bits sent, then RSEL dropped -> FRAME_ERR pulse, DATA keeps the previous 0xA5. The next full frame 0x3C completes correctly.
- Timeout: TIMEOUT_CYCLES=16, 3 bits then RCLK stalls for 20 CLK -> FRAME_ERR 16 cycles after the last sample, BUSY falls. A following 8-bit 0xFF frame gives DATA=0xFF.
- Reset mid-word: RESET asserted after 4 bits -> no FRAME_ERR, DATA=0, counter 0. The next frame 0x81 gives DATA=0x81.

Source files
------------

// File: rtl/sensor_serial_pkg.sv
// Shared types and helpers for the sensor serial receiver.
package sensor_serial_pkg;

  // Word assembly state: waiting for the first bit, or collecting the rest.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Timeout counter width; only has to reach cycles-1, so log2 is enough.
  function automatic int tmo_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

  // Bit counter width; sized so the value WIDTH itself is representable.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_sync_edge.sv
// Multi-flop synchroniser for one asynchronous line, with a registered
// rise detector. level_o is delayed to line up with rise_o, so several
// instances fed from the same pin edge present aligned samples.
module serial_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;

  // Synchroniser chain, previous-level flop and registered rise event.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign level_o = prev_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/sensor_serial_rx.sv
// Serial sensor word receiver. Synchronises RCLK/RDATA/RSEL into the CLK
// domain, samples RDATA on RCLK rising edges while RSEL is high, and
// assembles WIDTH-bit words. Partial words are dropped with FRAME_ERR
// when RSEL falls or the serial clock stalls.
module sensor_serial_rx
  import sensor_serial_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter bit LSB_FIRST      = 1'b1,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             RCLK,
  input  logic             RDATA,
  input  logic             RSEL,
  output logic [WIDTH-1:0] DATA,
  output logic             DATA_VALID,
  output logic             FRAME_ERR,
  output logic             BUSY
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int TMO_W = tmo_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic rclk_rise;
  logic rdata_s;
  logic rsel_s;
  logic unused_rdata_rise;
  logic unused_rsel_rise;

  serial_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rclk (
    .clk     (CLK),
    .rst     (RESET),
    .d_i     (RCLK),
    .level_o (),
    .rise_o  (rclk_rise)
  );

  serial_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rdata (
    .clk     (CLK),
    .rst     (RESET),
    .d_i     (RDATA),
    .level_o (rdata_s),
    .rise_o  (unused_rdata_rise)
  );

  serial_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rsel (
    .clk     (CLK),
    .rst     (RESET),
    .d_i     (RSEL),
    .level_o (rsel_s),
    .rise_o  (unused_rsel_rise)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               dv_q, dv_d;
  logic               fe_q, fe_d;
  logic [WIDTH-1:0]   word_in;
  logic               sample;

  assign sample = rclk_rise & rsel_s;

  // Shift register contents after accepting the current RDATA sample.
  always_comb begin
    if (LSB_FIRST) begin
      word_in = {rdata_s, shift_q[WIDTH-1:1]};
    end else begin
      word_in = {shift_q[WIDTH-2:0], rdata_s};
    end
  end

  // Next-state logic: sample events take priority over abort conditions,
  // so a final bit arriving with a timeout still completes the word.
  // NOTE: every signal gets its default before any branch; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;

    if (sample) begin
      tmo_d = '0;
      if (cnt_q == CNT_LAST) begin
        data_d  = word_in;
        dv_d    = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        shift_d = word_in;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = SHIFT;
      end
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          tmo_d = '0;
        end
        SHIFT: begin
          if (!rsel_s || (tmo_q == TMO_LAST)) begin
            fe_d    = 1'b1;
            cnt_d   = '0;
            tmo_d   = '0;
            state_d = IDLE;
          end else if (tmo_q != '1) begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      endcase
    end
  end

  // State, counters, assembled word and output pulse registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
    end
  end

  assign DATA       = data_q;
  assign DATA_VALID = dv_q;
  assign FRAME_ERR  = fe_q;
  assign BUSY       = (state_q == SHIFT);

endmodule

// File: tb/tb_sensor_serial_rx.sv
// Directed bench for sensor_serial_rx: an 8-bit LSB-first instance with a
// short timeout and a 12-bit MSB-first instance, sharing clock and reset.
module tb_sensor_serial_rx;

  localparam int HALF = 4;  // CLK periods per RCLK half period
  localparam int LAT  = 4;  // SYNC_STAGES + 2

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RESET;
  logic        rclk8, rdata8, rsel8;
  logic [7:0]  data8;
  logic        dv8, fe8, busy8;
  logic        rclk12, rdata12, rsel12;
  logic [11:0] data12;
  logic        dv12, fe12, busy12;

  sensor_serial_rx #(
    .WIDTH(8), .LSB_FIRST(1'b1), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)
  ) u_dut8 (
    .CLK(CLK), .RESET(RESET), .RCLK(rclk8), .RDATA(rdata8), .RSEL(rsel8),
    .DATA(data8), .DATA_VALID(dv8), .FRAME_ERR(fe8), .BUSY(busy8)
  );

  sensor_serial_rx #(
    .WIDTH(12), .LSB_FIRST(1'b0), .SYNC_STAGES(2), .TIMEOUT_CYCLES(1024)
  ) u_dut12 (
    .CLK(CLK), .RESET(RESET), .RCLK(rclk12), .RDATA(rdata12), .RSEL(rsel12),
    .DATA(data12), .DATA_VALID(dv12), .FRAME_ERR(fe12), .BUSY(busy12)
  );

  int cyc = 0;
  always @(posedge CLK) cyc++;

  // Pulse monitors, sampled on the falling edge.
  int dv8_cnt = 0, dv8_cyc = -1, fe8_cnt = 0, fe8_cyc = -1;
  int dv12_cnt = 0, fe12_cnt = 0, both_hi = 0;
  always @(negedge CLK) begin
    if (dv8 === 1'b1)  begin dv8_cnt++; dv8_cyc = cyc; end
    if (fe8 === 1'b1)  begin fe8_cnt++; fe8_cyc = cyc; end
    if (dv12 === 1'b1) dv12_cnt++;
    if (fe12 === 1'b1) fe12_cnt++;
    if ((dv8 === 1'b1 && fe8 === 1'b1) || (dv12 === 1'b1 && fe12 === 1'b1)) both_hi++;
  end

  int n_vec = 0;
  int n_err = 0;
  int last_rise = 0;
  int t0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One serial bit: data set with RCLK low, rising edge, then falling edge.
  task automatic send_bit(input int which, input logic b);
    @(negedge CLK);
    if (which == 8) rdata8 = b; else rdata12 = b;
    wait_cyc(HALF);
    if (which == 8) rclk8 = 1'b1; else rclk12 = 1'b1;
    last_rise = cyc;
    wait_cyc(HALF);
    if (which == 8) rclk8 = 1'b0; else rclk12 = 1'b0;
  endtask

  // First n bits of w, LSB first, to the 8-bit instance.
  task automatic send8(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(8, w[i]);
  endtask

  // Full 12-bit word, MSB first, to the 12-bit instance.
  task automatic send12(input logic [11:0] w);
    for (int i = 11; i >= 0; i--) send_bit(12, w[i]);
  endtask

  initial begin
    RESET = 1'b1;
    rclk8 = 1'b0; rdata8 = 1'b0; rsel8 = 1'b0;
    rclk12 = 1'b0; rdata12 = 1'b0; rsel12 = 1'b0;
    wait_cyc(3);
    RESET = 1'b0;

    // Idle: RCLK toggles with RSEL low, nothing is captured.
    for (int i = 0; i < 3; i++) begin
      send_bit(8, 1'b1);
      send_bit(12, 1'b1);
    end
    wait_cyc(4);
    check("idle_data8", 32'(data8), 32'h0);
    check("idle_dv8", 32'(dv8_cnt), 32'd0);
    check("idle_fe8", 32'(fe8_cnt), 32'd0);
    check("idle_busy8", 32'(busy8), 32'd0);
    check("idle_data12", 32'(data12), 32'h0);

    // LSB-first byte 0xA5 with latency measurement.
    rsel8 = 1'b1;
    wait_cyc(5);
    send8(8'hA5, 8);
    t0 = last_rise;
    wait_cyc(2);
    check("a5_data", 32'(data8), 32'hA5);
    check("a5_dv_cnt", 32'(dv8_cnt), 32'd1);
    check("a5_latency", 32'(dv8_cyc - t0), 32'(LAT));
    check("a5_busy", 32'(busy8), 32'd0);
    check("a5_fe", 32'(fe8_cnt), 32'd0);

    // MSB-first 12-bit words, back to back.
    rsel12 = 1'b1;
    wait_cyc(5);
    send12(12'hC3A);
    check("c3a_dv", 32'(dv12), 32'd1);
    check("c3a_data", 32'(data12), 32'hC3A);
    send12(12'h001);
    wait_cyc(2);
    check("b2b_data", 32'(data12), 32'h001);
    check("b2b_dv_cnt", 32'(dv12_cnt), 32'd2);
    check("b2b_fe", 32'(fe12_cnt), 32'd0);

    // RSEL dropped after 5 bits: frame error, DATA held.
    send8(8'h5A, 5);
    check("abort_busy_mid", 32'(busy8), 32'd1);
    rsel8 = 1'b0;
    wait_cyc(8);
    check("abort_fe_cnt", 32'(fe8_cnt), 32'd1);
    check("abort_data", 32'(data8), 32'hA5);
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_dv_cnt", 32'(dv8_cnt), 32'd1);
    rsel8 = 1'b1;
    wait_cyc(5);
    send8(8'h3C, 8);
    wait_cyc(2);
    check("3c_data", 32'(data8), 32'h3C);
    check("3c_dv_cnt", 32'(dv8_cnt), 32'd2);

    // Stall after 3 bits: timeout fires 16 cycles after the last sample.
    send8(8'h07, 3);
    t0 = last_rise;
    check("tmo_busy_mid", 32'(busy8), 32'd1);
    wait_cyc(24);
    check("tmo_fe_cnt", 32'(fe8_cnt), 32'd2);
    check("tmo_fe_time", 32'(fe8_cyc - t0), 32'(LAT + 16));
    check("tmo_busy", 32'(busy8), 32'd0);
    check("tmo_data", 32'(data8), 32'h3C);
    send8(8'hFF, 8);
    wait_cyc(2);
    check("ff_data", 32'(data8), 32'hFF);
    check("ff_dv_cnt", 32'(dv8_cnt), 32'd3);

    // Reset after 4 bits: partial word dropped silently, DATA cleared.
    send8(8'h0F, 4);
    check("rst_busy_mid", 32'(busy8), 32'd1);
    @(negedge CLK);
    RESET = 1'b1;
    wait_cyc(2);
    RESET = 1'b0;
    wait_cyc(2);
    check("rst_fe_cnt", 32'(fe8_cnt), 32'd2);
    check("rst_data8", 32'(data8), 32'h0);
    check("rst_data12", 32'(data12), 32'h0);
    check("rst_busy", 32'(busy8), 32'd0);
    send8(8'h81, 8);
    wait_cyc(2);
    check("81_data", 32'(data8), 32'h81);
    check("81_dv_cnt", 32'(dv8_cnt), 32'd4);
    check("81_fe_cnt", 32'(fe8_cnt), 32'd2);

    check("dv_fe_exclusive", 32'(both_hi), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
